// File: rtl/cpu_ctrl.sv
// Mini-CPU control unit: captures an instruction on a button press, runs it over a
// 16x16 register file and holds the result for the LCD stage. Optional: CPU_SATURATE_EN.
module cpu_ctrl #(
    parameter int unsigned SHOW_CYCLES = 4_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] sw,
    input  logic        send_n,
    output logic [3:0]  estadoCpu,
    output logic [2:0]  opcode,
    output logic [3:0]  reg1,
    output logic [3:0]  reg2,
    output logic [3:0]  reg3,
    output logic [15:0] result,
    output logic        busy
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned CNT_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_WRITEBACK = 4'd4,
        S_SHOW      = 4'd5
    } state_t;

    state_t                    r_state;
    logic                      r_sync1;
    logic                      r_sync2;
    logic                      r_sync3;
    logic                      w_press;
    logic signed [6:0]         r_imm7;
    logic signed [DATA_W-1:0]  r_imm;
    logic signed [DATA_W-1:0]  r_a;
    logic signed [DATA_W-1:0]  r_b;
    logic        [DATA_W-1:0]  r_d;
    logic        [DATA_W-1:0]  r_v;
    logic        [DATA_W-1:0]  w_v;
    logic        [CNT_W-1:0]   r_cnt;
    logic        [DATA_W-1:0]  r_regs [NREGS];

    // Sign-magnitude view of a two's-complement value; -32768 clamps to magnitude 32767.
    function automatic logic [DATA_W-1:0] to_sm(input logic [DATA_W-1:0] v);
        logic [DATA_W-2:0] mag;
        mag = ~v[DATA_W-2:0] + 15'd1;
        if (!v[DATA_W-1])
            return {1'b0, v[DATA_W-2:0]};
        else if (v == 16'h8000)
            return 16'hFFFF;
        else
            return {1'b1, mag};
    endfunction

`ifdef CPU_SATURATE_EN
    logic signed [DATA_W:0]     w_add;
    logic signed [DATA_W:0]     w_addi;
    logic signed [DATA_W:0]     w_sub;
    logic signed [DATA_W:0]     w_subi;
    logic signed [2*DATA_W-1:0] w_prod;

    assign w_add  = 17'(r_a) + 17'(r_b);
    assign w_addi = 17'(r_a) + 17'(r_imm);
    assign w_sub  = 17'(r_a) - 17'(r_b);
    assign w_subi = 17'(r_a) - 17'(r_imm);
    assign w_prod = 32'(r_a) * 32'(r_imm);

    function automatic logic [DATA_W-1:0] sat17(input logic signed [DATA_W:0] x);
        if (x > 17'sd32767)
            return 16'h7FFF;
        else if (x < -17'sd32767)
            return 16'h8001;
        else
            return 16'(x);
    endfunction

    function automatic logic [DATA_W-1:0] sat32(input logic signed [2*DATA_W-1:0] x);
        if (x > 32'sd32767)
            return 16'h7FFF;
        else if (x < -32'sd32767)
            return 16'h8001;
        else
            return 16'(x);
    endfunction
`endif

    // ALU: value produced by the latched instruction
    always_comb begin
        w_v = '0;
        case (opcode)
            OP_LOAD:    w_v = r_imm;
`ifdef CPU_SATURATE_EN
            OP_ADD:     w_v = sat17(w_add);
            OP_ADDI:    w_v = sat17(w_addi);
            OP_SUB:     w_v = sat17(w_sub);
            OP_SUBI:    w_v = sat17(w_subi);
            OP_MUL:     w_v = sat32(w_prod);
`else
            OP_ADD:     w_v = r_a + r_b;
            OP_ADDI:    w_v = r_a + r_imm;
            OP_SUB:     w_v = r_a - r_b;
            OP_SUBI:    w_v = r_a - r_imm;
            OP_MUL:     w_v = 16'(r_a * r_imm);
`endif
            OP_CLEAR:   w_v = '0;
            OP_DISPLAY: w_v = r_d;
            default:    w_v = '0;
        endcase
    end

    // Button synchroniser; r_sync3 is the edge-detect history flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= send_n;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_press   = r_sync3 & ~r_sync2;
    assign estadoCpu = r_state;

    // Sequencer, register file and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            opcode  <= '0;
            reg1    <= '0;
            reg2    <= '0;
            reg3    <= '0;
            result  <= '0;
            r_imm7  <= '0;
            r_imm   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_v     <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        r_state <= S_FETCH;
                        busy    <= 1'b1;
                        opcode  <= sw[17:15];
                        reg1    <= sw[14:11];
                        reg2    <= sw[10:7];
                        reg3    <= sw[6:3];
                        r_imm7  <= sw[6:0];
                    end
                end
                S_FETCH: begin
                    r_a     <= r_regs[reg2];
                    r_b     <= r_regs[reg3];
                    r_d     <= r_regs[reg1];
                    r_imm   <= 16'(r_imm7);
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_v     <= w_v;
                    r_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (opcode == OP_CLEAR) begin
                        for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
                    end else if (opcode != OP_DISPLAY) begin
                        r_regs[reg1] <= r_v;
                    end
                    result  <= to_sm(r_v);
                    r_state <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    r_cnt   <= '0;
                    r_state <= S_SHOW;
                end
                S_SHOW: begin
                    if (r_cnt == CNT_W'(SHOW_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
